branch_resolution_unit: RTL and testbench

- EX-stage counterpart of the fetch-side branch predictor.
- Keeps an in-order queue of the predictions fetch made for each in-flight instruction.
- When an instruction leaves EX, it compares the actual next PC with the predicted next PC. It then drives the predictor's resolve_* update interface and raises a registered flush/redirect on a mismatch.
- It also keeps misprediction statistics for visualization.

---
 rtl/branch_resolution_unit.sv | 159 +++++++++++++++
 tb/tb_branch_resolution_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolution_unit.sv
// EX-stage branch resolution: matches each resolving instruction against the
// in-order queue of fetch predictions, updates the predictor and flushes on a miss.
module branch_resolution_unit #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_push,
  input  logic [31:0]       pred_pc,
  input  logic              pred_hit,
  input  logic              pred_taken,
  input  logic [31:0]       pred_target,
  output logic              pred_ready,
  input  logic              ex_valid,
  input  logic [31:0]       ex_pc,
  input  logic              ex_is_branch,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  output logic              resolve_valid,
  output logic [31:0]       resolve_pc,
  output logic              resolve_taken,
  output logic [31:0]       resolve_target,
  output logic              resolve_is_branch,
  output logic              was_predicted_taken,
  output logic              flush,
  output logic [31:0]       redirect_pc,
  output logic [PTR_W:0]    queue_count,
  output logic [CNT_W-1:0]  branch_count,
  output logic [CNT_W-1:0]  mispredict_count,
  output logic              overflow,
  output logic              sync_error
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [31:0]      pc_mem     [DEPTH];
  logic             hit_mem    [DEPTH];
  logic             taken_mem  [DEPTH];
  logic [31:0]      target_mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;

  logic [31:0] head_pc, head_target, pred_next, act_next;
  logic        head_hit, head_taken, queue_empty, sync_fault;
  logic        ex_act, flush_now, push_ok, pop_ok;

  logic              vld_p1, taken_p1, is_branch_p1, wpt_p1, flush_p1;
  logic [31:0]       pc_p1, target_p1, redirect_p1;
  logic [CNT_W-1:0]  branch_cnt_p1, mispredict_cnt_p1;
  logic              overflow_q, sync_error_q;

  // Stage 0: head lookup and next-PC comparison
  always_comb begin
    head_pc     = pc_mem[rd_ptr];
    head_hit    = hit_mem[rd_ptr];
    head_taken  = taken_mem[rd_ptr];
    head_target = target_mem[rd_ptr];
    queue_empty = (count == '0);
    // A resolve arriving in the flush cycle belongs to the wrong path.
    ex_act      = ex_valid && !flush_p1;
    sync_fault  = queue_empty || (head_pc != ex_pc);
    if (sync_fault)
      pred_next = ex_pc + 32'd4;
    else if (head_hit && head_taken)
      pred_next = head_target;
    else
      pred_next = head_pc + 32'd4;
    act_next   = (ex_is_branch && ex_taken) ? ex_target : ex_pc + 32'd4;
    flush_now  = ex_act && (sync_fault || (pred_next != act_next));
    push_ok    = pred_push && pred_ready && !flush_now && !flush_p1;
    pop_ok     = ex_act && !queue_empty && !flush_now;
  end

  assign pred_ready = (count != FULL_CNT);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      pc_mem[wr_ptr]     <= pred_pc;
      hit_mem[wr_ptr]    <= pred_hit;
      taken_mem[wr_ptr]  <= pred_taken;
      target_mem[wr_ptr] <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Stage 1: registered resolve, flush and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1            <= 1'b0;
      pc_p1             <= '0;
      taken_p1          <= 1'b0;
      target_p1         <= '0;
      is_branch_p1      <= 1'b0;
      wpt_p1            <= 1'b0;
      flush_p1          <= 1'b0;
      redirect_p1       <= '0;
      branch_cnt_p1     <= '0;
      mispredict_cnt_p1 <= '0;
      overflow_q        <= 1'b0;
      sync_error_q      <= 1'b0;
    end else begin
      vld_p1   <= ex_act;
      flush_p1 <= flush_now;
      if (ex_act) begin
        pc_p1        <= ex_pc;
        taken_p1     <= ex_is_branch && ex_taken;
        target_p1    <= ex_target;
        is_branch_p1 <= ex_is_branch;
        wpt_p1       <= !sync_fault && head_hit && head_taken;
        redirect_p1  <= act_next;
      end
      if (ex_act && ex_is_branch) branch_cnt_p1     <= sat_inc(branch_cnt_p1);
      if (flush_now)              mispredict_cnt_p1 <= sat_inc(mispredict_cnt_p1);
      if (pred_push && !pred_ready) overflow_q      <= 1'b1;
      if (ex_act && sync_fault)     sync_error_q    <= 1'b1;
    end
  end

  assign resolve_valid       = vld_p1;
  assign resolve_pc          = pc_p1;
  assign resolve_taken       = taken_p1;
  assign resolve_target      = target_p1;
  assign resolve_is_branch   = is_branch_p1;
  assign was_predicted_taken = wpt_p1;
  assign flush               = flush_p1;
  assign redirect_pc         = redirect_p1;
  assign queue_count         = count;
  assign branch_count        = branch_cnt_p1;
  assign mispredict_count    = mispredict_cnt_p1;
  assign overflow            = overflow_q;
  assign sync_error          = sync_error_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with hand-computed expectations.
module tb_branch_resolution_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_push, pred_hit, pred_taken;
  logic [31:0] pred_pc, pred_target;
  logic        pred_ready;
  logic        ex_valid, ex_is_branch, ex_taken;
  logic [31:0] ex_pc, ex_target;
  logic        resolve_valid, resolve_taken, resolve_is_branch, was_predicted_taken;
  logic [31:0] resolve_pc, resolve_target, redirect_pc;
  logic        flush, overflow, sync_error;
  logic [3:0]  queue_count;
  logic [15:0] branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  branch_resolution_unit #(.DEPTH(8), .PTR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .pred_push(pred_push), .pred_pc(pred_pc), .pred_hit(pred_hit),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_ready(pred_ready),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .resolve_is_branch(resolve_is_branch), .was_predicted_taken(was_predicted_taken),
    .flush(flush), .redirect_pc(redirect_pc), .queue_count(queue_count),
    .branch_count(branch_count), .mispredict_count(mispredict_count),
    .overflow(overflow), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic en, input logic [31:0] pc, input logic hit,
                          input logic tk, input logic [31:0] tgt);
    pred_push = en; pred_pc = pc; pred_hit = hit; pred_taken = tk; pred_target = tgt;
  endtask

  task automatic set_ex(input logic en, input logic [31:0] pc, input logic br,
                        input logic tk, input logic [31:0] tgt);
    ex_valid = en; ex_pc = pc; ex_is_branch = br; ex_taken = tk; ex_target = tgt;
  endtask

  initial begin
    rst = 1'b1;
    set_push(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset held two cycles with pushes active
    tick(); tick();
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_ready", 32'(pred_ready), 32'd1);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_resolve_valid", 32'(resolve_valid), 32'd0);
    chk("rst_branch_cnt", 32'(branch_count), 32'd0);
    chk("rst_mispredict_cnt", 32'(mispredict_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_sync_error", 32'(sync_error), 32'd0);
    rst = 1'b0;
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Correct not-taken
    set_push(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
    tick();
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("nt_count_after_push", 32'(queue_count), 32'd1);
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h500);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("nt_resolve_valid", 32'(resolve_valid), 32'd1);
    chk("nt_resolve_pc", resolve_pc, 32'h100);
    chk("nt_wpt", 32'(was_predicted_taken), 32'd0);
    chk("nt_flush", 32'(flush), 32'd0);
    chk("nt_branch_cnt", 32'(branch_count), 32'd1);
    chk("nt_count", 32'(queue_count), 32'd0);
    tick();
    chk("nt_resolve_valid_drop", 32'(resolve_valid), 32'd0);

    // Direction mispredict
    set_push(1'b1, 32'h200, 1'b1, 1'b1, 32'h400);
    tick();
    set_push(1'b1, 32'h204, 1'b0, 1'b0, 32'h0);
    tick();
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("dir_count_before", 32'(queue_count), 32'd2);
    set_ex(1'b1, 32'h200, 1'b1, 1'b0, 32'h400);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("dir_flush", 32'(flush), 32'd1);
    chk("dir_redirect", redirect_pc, 32'h204);
    chk("dir_mispredict_cnt", 32'(mispredict_count), 32'd1);
    chk("dir_count", 32'(queue_count), 32'd0);
    chk("dir_resolve_taken", 32'(resolve_taken), 32'd0);
    chk("dir_wpt", 32'(was_predicted_taken), 32'd1);
    chk("dir_branch_cnt", 32'(branch_count), 32'd2);
    tick();
    chk("dir_flush_one_cycle", 32'(flush), 32'd0);

    // Target mispredict
    set_push(1'b1, 32'h200, 1'b1, 1'b1, 32'h400);
    tick();
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 32'h200, 1'b1, 1'b1, 32'h480);
    tick();
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("tgt_flush", 32'(flush), 32'd1);
    chk("tgt_redirect", redirect_pc, 32'h480);
    chk("tgt_resolve_target", resolve_target, 32'h480);
    chk("tgt_resolve_taken", 32'(resolve_taken), 32'd1);
    chk("tgt_mispredict_cnt", 32'(mispredict_count), 32'd2);
    tick();
    chk("tgt_flush_one_cycle", 32'(flush), 32'd0);

    // Fill to full, then one dropped push
    for (int i = 0; i < 8; i++) begin
      set_push(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'h0);
      tick();
    end
    chk("full_count", 32'(queue_count), 32'd8);
    chk("full_ready", 32'(pred_ready), 32'd0);
    chk("full_overflow_clear", 32'(overflow), 32'd0);
    set_push(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0);
    tick();
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(queue_count), 32'd8);

    // One pop, then steady push+pop with pointer wrap
    set_ex(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_first_pc", resolve_pc, 32'h1000);
    chk("wrap_first_count", 32'(queue_count), 32'd7);
    for (int k = 0; k < 20; k++) begin
      set_push(1'b1, 32'h1020 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
      set_ex(1'b1, 32'h1004 + 32'(4 * k), 1'b0, 1'b0, 32'h0);
      tick();
      chk("wrap_pc", resolve_pc, 32'h1004 + 32'(4 * k));
      chk("wrap_flush", 32'(flush), 32'd0);
      chk("wrap_count", 32'(queue_count), 32'd7);
    end
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int d = 0; d < 7; d++) begin
      set_ex(1'b1, 32'h1054 + 32'(4 * d), 1'b0, 1'b0, 32'h0);
      tick();
      chk("drain_pc", resolve_pc, 32'h1054 + 32'(4 * d));
      chk("drain_count", 32'(queue_count), 32'(6 - d));
    end
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drain_flush", 32'(flush), 32'd0);
    chk("drain_mispredict_cnt", 32'(mispredict_count), 32'd2);
    chk("drain_sync_clear", 32'(sync_error), 32'd0);

    // Desync on empty queue
    set_ex(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
    tick();
    chk("desync_sync_error", 32'(sync_error), 32'd1);
    chk("desync_flush", 32'(flush), 32'd1);
    chk("desync_redirect", redirect_pc, 32'h304);
    chk("desync_wpt", 32'(was_predicted_taken), 32'd0);
    chk("desync_mispredict_cnt", 32'(mispredict_count), 32'd3);
    // Push and resolve in the flush cycle are both wrong-path
    set_push(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    set_ex(1'b1, 32'h999, 1'b1, 1'b1, 32'h0);
    tick();
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("desync_push_dropped", 32'(queue_count), 32'd0);
    chk("desync_ex_ignored_valid", 32'(resolve_valid), 32'd0);
    chk("desync_ex_ignored_flush", 32'(flush), 32'd0);
    chk("desync_ex_ignored_cnt", 32'(mispredict_count), 32'd3);

    // Mid-operation reset discards queue and sticky state
    set_push(1'b1, 32'h600, 1'b0, 1'b0, 32'h0);
    tick();
    chk("mid_count_before", 32'(queue_count), 32'd1);
    rst = 1'b1;
    set_ex(1'b1, 32'h600, 1'b1, 1'b1, 32'h800);
    tick();
    rst = 1'b0;
    set_push(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    set_ex(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_count", 32'(queue_count), 32'd0);
    chk("mid_rst_flush", 32'(flush), 32'd0);
    chk("mid_rst_resolve_valid", 32'(resolve_valid), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    chk("mid_rst_sync_error", 32'(sync_error), 32'd0);
    chk("mid_rst_branch_cnt", 32'(branch_count), 32'd0);
    chk("mid_rst_mispredict_cnt", 32'(mispredict_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
